rv32_decode_stage: RTL and testbench

- RV32I decode stage: takes a fetched instruction and PC, and produces the ALU control code, operand selects, immediate and control flags.
- The result is held in a single-entry output register with valid/ready handshakes on both sides.
- Sits between fetch and the execute stage. Its out_alu_control drives the ALU's 4-bit alu_control input directly, so it is the producer end of that interface.

---
 rtl/rv32_pkg.sv | 51 +++++
 rtl/rv32_imm_gen.sv | 19 +
 rtl/rv32_decode_stage.sv | 151 +++++++++++++++
 tb/tb_rv32_decode_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcodes, ALU op codes, operand selects and decode types
package rv32_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] src_a_sel;
    logic       src_b_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_invert;
    logic       jump;
    logic       link;
    logic       illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_ILLEGAL = '{alu: ALU_ADD, illegal: 1'b1, default: '0};
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: builds the sign-extended RV32I immediate for a given format
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_t        imm_type,
  output logic [31:0] imm
);
  logic s;
  assign s = instr[31];
  always_comb begin
    imm = imm_type == IMM_I ? {{21{s}}, instr[30:20]} :
          imm_type == IMM_S ? {{21{s}}, instr[30:25], instr[11:7]} :
          imm_type == IMM_B ? {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
          32'b0;
  end
endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: RV32I decoder with a single-entry valid/ready output register
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_control,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [1:0]      out_src_a_sel,
  output logic            out_src_b_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_branch_invert,
  output logic            out_jump,
  output logic            out_link,
  output logic            out_illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       accept;
  ctrl_t      c, d, q;
  imm_t       it, imm_type;
  logic [31:0] imm;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready && !flush;
  always_comb begin
    c = '0;
    c.alu = ALU_ADD;
    it = IMM_NONE;
    case (opc)
      OPC_OP: begin
        c.alu = alu_of(f3, f7[5]);
        c.reg_write = 1'b1;
        c.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        c.alu = alu_of(f3, f3 == 3'b101 && f7[5]);
        c.src_b_imm = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_I;
        c.illegal = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LOAD: begin
        c.src_b_imm = 1'b1;
        c.mem_read = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_I;
        c.illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        c.src_b_imm = 1'b1;
        c.mem_write = 1'b1;
        it = IMM_S;
        c.illegal = f3[2] || f3 == 3'b011;
      end
      OPC_BRANCH: begin
        c.alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : (f3[0] ? ALU_BNE : ALU_BEQ);
        c.branch = 1'b1;
        c.branch_invert = f3[2] && f3[0];
        it = IMM_B;
        c.illegal = f3[2:1] == 2'b01;
      end
      OPC_LUI: begin
        c.src_a_sel = SRC_A_ZERO;
        c.src_b_imm = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_U;
      end
      OPC_AUIPC: begin
        c.src_a_sel = SRC_A_PC;
        c.src_b_imm = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_U;
      end
      OPC_JAL: begin
        c.src_a_sel = SRC_A_PC;
        c.src_b_imm = 1'b1;
        c.jump = 1'b1;
        c.link = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_J;
      end
      OPC_JALR: begin
        c.src_b_imm = 1'b1;
        c.jump = 1'b1;
        c.link = 1'b1;
        c.reg_write = 1'b1;
        it = IMM_I;
        c.illegal = f3 != 3'b000;
      end
      default: c.illegal = 1'b1;
    endcase
    d = c.illegal ? CTRL_ILLEGAL : c;
    imm_type = c.illegal ? IMM_NONE : it;
  end
  rv32_imm_gen u_imm (.instr(in_instr), .imm_type(imm_type), .imm(imm));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc <= RESET_PC;
      out_imm <= '0;
      out_rs1 <= '0;
      out_rs2 <= '0;
      out_rd <= '0;
      q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      q <= '{alu: q.alu, src_a_sel: q.src_a_sel, src_b_imm: q.src_b_imm, default: 1'b0};
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_imm <= imm;
      out_rs1 <= in_instr[19:15];
      out_rs2 <= in_instr[24:20];
      out_rd <= in_instr[11:7];
      q <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  assign out_alu_control = q.alu;
  assign out_src_a_sel = q.src_a_sel;
  assign out_src_b_imm = q.src_b_imm;
  assign out_reg_write = q.reg_write;
  assign out_mem_read = q.mem_read;
  assign out_mem_write = q.mem_write;
  assign out_branch = q.branch;
  assign out_branch_invert = q.branch_invert;
  assign out_jump = q.jump;
  assign out_link = q.link;
  assign out_illegal = q.illegal;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb_rv32_decode_stage: directed-vector bench for the RV32I decode stage
module tb_rv32_decode_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm;
  logic [3:0] out_alu_control;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [1:0] out_src_a_sel;
  logic out_src_b_imm, out_reg_write, out_mem_read, out_mem_write, out_branch;
  logic out_branch_invert, out_jump, out_link, out_illegal;
  int total = 0, bad = 0;
  rv32_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_control(out_alu_control), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_src_a_sel(out_src_a_sel), .out_src_b_imm(out_src_b_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_branch_invert(out_branch_invert), .out_jump(out_jump),
    .out_link(out_link), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, RPC);
    chk("rst_alu", out_alu_control, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_rw", out_reg_write, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    issue(32'h002081B3, 32'h1000);
    chk("add_valid", out_valid, 1);
    chk("add_alu", out_alu_control, 4'b0011);
    chk("add_rs1", out_rs1, 1);
    chk("add_rs2", out_rs2, 2);
    chk("add_rd", out_rd, 3);
    chk("add_bimm", out_src_b_imm, 0);
    chk("add_rw", out_reg_write, 1);
    chk("add_pc", out_pc, 32'h1000);
    issue(32'h402081B3, 32'h1004);
    chk("sub_alu", out_alu_control, 4'b0100);
    issue(32'hFFF00093, 32'h1008);
    chk("addi_alu", out_alu_control, 4'b0011);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_bimm", out_src_b_imm, 1);
    chk("addi_rd", out_rd, 1);
    issue(32'h4032D293, 32'h100C);
    chk("srai_alu", out_alu_control, 4'b0111);
    chk("srai_sh", out_imm[4:0], 3);
    issue(32'h0020D463, 32'h1010);
    chk("bge_alu", out_alu_control, 4'b1000);
    chk("bge_br", out_branch, 1);
    chk("bge_inv", out_branch_invert, 1);
    chk("bge_imm", out_imm, 8);
    chk("bge_rw", out_reg_write, 0);
    chk("bge_bimm", out_src_b_imm, 0);
    issue(32'h0080A103, 32'h1014);
    chk("lw_mr", out_mem_read, 1);
    chk("lw_rw", out_reg_write, 1);
    chk("lw_imm", out_imm, 8);
    issue(32'hFE20AE23, 32'h1018);
    chk("sw_mw", out_mem_write, 1);
    chk("sw_imm", out_imm, 32'hFFFF_FFFC);
    chk("sw_rw", out_reg_write, 0);
    issue(32'h123452B7, 32'h101C);
    chk("lui_sa", out_src_a_sel, 2);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_alu", out_alu_control, 4'b0011);
    issue(32'h12345297, 32'h1020);
    chk("auipc_sa", out_src_a_sel, 1);
    issue(32'h010000EF, 32'h1024);
    chk("jal_imm", out_imm, 16);
    chk("jal_jl", {out_jump, out_link, out_reg_write}, 3'b111);
    chk("jal_sa", out_src_a_sel, 1);
    issue(32'h004100E7, 32'h1028);
    chk("jalr_imm", out_imm, 4);
    chk("jalr_sa", out_src_a_sel, 0);
    chk("jalr_j", out_jump, 1);
    issue(32'h00000000, 32'h102C);
    chk("ill0_flag", out_illegal, 1);
    chk("ill0_valid", out_valid, 1);
    chk("ill0_rw", out_reg_write, 0);
    chk("ill0_alu", out_alu_control, 4'b0011);
    issue(32'h0220A0B3, 32'h1030);
    chk("ill7_flag", out_illegal, 1);
    chk("ill7_rw", out_reg_write, 0);
    chk("ill7_alu", out_alu_control, 4'b0011);
    issue(32'h002081B3, 32'h2000);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h402081B3;
    in_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_alu", out_alu_control, 4'b0011);
      chk("bp_pc", out_pc, 32'h2000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_next_alu", out_alu_control, 4'b0100);
    chk("bp_next_pc", out_pc, 32'h3000);
    in_instr = 32'hFFF00093;
    in_pc = 32'h3004;
    step();
    chk("stream_valid", out_valid, 1);
    chk("stream_pc", out_pc, 32'h3004);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    issue(32'h002081B3, 32'h4000);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h402081B3;
    in_pc = 32'h5000;
    flush = 1'b1;
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_rw", out_reg_write, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush_dropped", out_valid, 0);
    issue(32'hFFF00093, 32'h6000);
    in_valid = 1'b1;
    rst = 1'b1;
    step();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pc", out_pc, RPC);
    chk("mrst_imm", out_imm, 0);
    chk("mrst_alu", out_alu_control, 0);
    chk("mrst_rd", out_rd, 0);
    chk("mrst_bimm", out_src_b_imm, 0);
    chk("mrst_rw", out_reg_write, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
